// File: rtl/shift_pkg.sv
// Shared definitions for the shift pipeline: direction encodings and the
// width-generic fill mask used for arithmetic right shifts.
package shift_pkg;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Widest data path the fill-mask helper supports.
  localparam int unsigned FILL_MAX_W = 64;

  // Mask with the top 'amt' bits of a 'width'-bit field set, zero elsewhere
  // (including every bit at or above 'width'). Callers keep amt <= width.
  function automatic logic [FILL_MAX_W-1:0] fill_mask(input int unsigned width,
                                                      input int unsigned amt);
    logic [FILL_MAX_W-1:0] top_s;
    logic [FILL_MAX_W-1:0] field_s;
    top_s   = {FILL_MAX_W{1'b1}} << (width - amt);
    field_s = {FILL_MAX_W{1'b1}} >> (FILL_MAX_W - width);
    return top_s & field_s;
  endfunction

endpackage

// File: rtl/shifter.sv
// Combinational logical shifter.
// Ports:
//   data   - operand
//   amount - shift distance, 0..WIDTH-1
//   dir    - DIR_LEFT or DIR_RIGHT
//   out    - logically shifted operand (zero fill)
module shifter
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]         data,
  input  logic [$clog2(WIDTH)-1:0] amount,
  input  logic                     dir,
  output logic [WIDTH-1:0]         out
);

  // Select shift direction.
  always_comb begin
    out = data;
    if (dir == DIR_LEFT) begin
      out = data << amount;
    end else begin
      out = data >> amount;
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Two-stage, flow-controlled shift unit. Commands enter the input register
// (S1) over a valid/ready handshake; the shift result, with arithmetic fill
// and out-of-range handling, lands in the output register (S2), which holds
// steady under backpressure.
// Ports:
//   i_clk, i_rst              - clock, synchronous active-high reset
//   i_in_valid / o_in_ready   - command handshake
//   i_data, i_shamt, i_dir,
//   i_arith                   - command operand, amount, direction, sign fill
//   o_out_valid / i_out_ready - result handshake
//   o_result, o_ovf           - shifted value, amount was >= WIDTH
//   o_busy                    - any command in flight
module shift_pipe
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic               i_dir,
  input  logic               i_arith,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [WIDTH-1:0]   o_result,
  output logic               o_ovf,
  output logic               o_busy
);

  localparam logic [SHAMT_W-1:0] OVF_LIMIT = SHAMT_W'(WIDTH);

  logic               s1_valid_r;
  logic [WIDTH-1:0]   s1_data_r;
  logic [SHAMT_W-1:0] s1_shamt_r;
  logic               s1_dir_r;
  logic               s1_arith_r;

  logic               adv2_s;
  logic               adv1_s;
  logic               accept_s;
  logic [WIDTH-1:0]   shift_out_s;
  logic [WIDTH-1:0]   mask_s;
  logic               ovf_s;
  logic               sign_fill_s;
  logic [WIDTH-1:0]   result_s;

  // S2 can take a new value when empty or draining this cycle.
  assign adv2_s     = !o_out_valid || i_out_ready;
  assign adv1_s     = s1_valid_r && adv2_s;
  assign o_in_ready = !s1_valid_r || adv2_s;
  assign accept_s   = i_in_valid && o_in_ready;
  assign o_busy     = s1_valid_r || o_out_valid;

  shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .data   (s1_data_r),
    .amount (s1_shamt_r[SHAMT_W-2:0]),
    .dir    (s1_dir_r),
    .out    (shift_out_s)
  );

  assign ovf_s       = (s1_shamt_r >= OVF_LIMIT);
  assign sign_fill_s = (s1_dir_r == DIR_RIGHT) && s1_arith_r;
  // Only consulted when !ovf_s, so the amount never exceeds WIDTH.
  assign mask_s      = WIDTH'(fill_mask(WIDTH, 32'(s1_shamt_r)));

  // Final result: out-of-range clamp, then sign fill for negative operands.
  always_comb begin
    result_s = shift_out_s;
    if (ovf_s) begin
      if (sign_fill_s) begin
        result_s = {WIDTH{s1_data_r[WIDTH-1]}};
      end else begin
        result_s = {WIDTH{1'b0}};
      end
    end else if (sign_fill_s && s1_data_r[WIDTH-1]) begin
      result_s = shift_out_s | mask_s;
    end else begin
      result_s = shift_out_s;
    end
  end

  // S1: load on accept, empty when its command moves to S2, else hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {WIDTH{1'b0}};
      s1_shamt_r <= {SHAMT_W{1'b0}};
      s1_dir_r   <= 1'b0;
      s1_arith_r <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_data_r  <= i_data;
      s1_shamt_r <= i_shamt;
      s1_dir_r   <= i_dir;
      s1_arith_r <= i_arith;
    end else if (adv1_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // S2: capture the result when S1 advances, clear once consumed, else hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_out_valid <= 1'b0;
      o_result    <= {WIDTH{1'b0}};
      o_ovf       <= 1'b0;
    end else if (adv1_s) begin
      o_out_valid <= 1'b1;
      o_result    <= result_s;
      o_ovf       <= ovf_s;
    end else if (o_out_valid && i_out_ready) begin
      o_out_valid <= 1'b0;
    end else begin
      o_out_valid <= o_out_valid;
    end
  end

endmodule
